mouse_receiver: RTL and testbench
=================================

# mouse_receiver

Device-to-host half of the PS/2 mouse link. It recovers 11-bit frames that the mouse drives on the PS/2 clock/data lines: start bit, 8 data bits LSB first, odd parity and stop bit. Each decoded byte is handed to the mouse master state machine with a one-cycle strobe and an error code. It shares the PS/2 lines with the transmitter: the transmitter owns host-to-device traffic, and this block listens only while the master enables it.

## Interface
- `TIMEOUT_CYCLES`, default 50000: maximum system-clock cycles between consecutive PS/2 falling edges inside a frame (1 ms at 50 MHz); must be ≥ 16.
- `CLK`  in  1  system clock, 50 MHz.
- `RESET`  in  1  asynchronous, active-high reset.
- `CLK_MOUSE_IN`  in  1  PS/2 clock line as seen at the pad; asynchronous to `CLK`.
- `DATA_MOUSE_IN`  in  1  PS/2 data line as seen at the pad; asynchronous to `CLK`.
- `READ_ENABLE`  in  1  from the master; a new frame may start only while high.
- `BYTE_READ`  out  8  last received data byte.
- `BYTE_ERROR_CODE`  out  2  bit0 = parity error, bit1 = stop-bit error; valid with `BYTE_READY`.
- `BYTE_READY`  out  1  single-cycle strobe: the frame is complete and the outputs are updated.

## Operation
- **Input conditioning:** `CLK_MOUSE_IN` and `DATA_MOUSE_IN` each pass through a 2-flop synchronizer.
  - A third flop on the clock path holds the previous synced value.
  - `fall` = previous & ~synced.
  - Data is sampled from its synced copy in the same cycle `fall` is high.
- **States:** IDLE, DATA, PARITY, STOP, DONE.
- **IDLE:**
  - On `fall` with `READ_ENABLE`=1 and data=0 (start bit): clear the bit counter, clear the shift register, go to DATA.
  - On `fall` with data=1 (glitch or no start bit): stay in IDLE.
  - With `READ_ENABLE`=0: `fall` is ignored.
- **DATA:**
  - On each `fall`, shift data into bit [7], shifting right, so the result is LSB-first.
  - A 3-bit counter increments on each shift; after the 8th bit (counter wraps 7→0) go to PARITY.
- **PARITY:** on `fall`, set the parity error if (XOR of the 8 data bits XOR the sampled bit) ≠ 1. Go to STOP.
- **STOP:** on `fall`, set the stop error if the sampled bit ≠ 1. Go to DONE.
- **DONE (one cycle):** load `BYTE_READ` from the shift register, load `BYTE_ERROR_CODE`, pulse `BYTE_READY`, return to IDLE.
- **Errored frames are still delivered.** A frame with a parity or stop error still pulses `BYTE_READY` with a nonzero code. The master decides whether to discard it.
- **Watchdog:**
  - The counter clears on every `fall` and in IDLE, and counts in DATA, PARITY and STOP.
  - On reaching `TIMEOUT_CYCLES`−1 it forces IDLE.
  - A timed-out frame produces no `BYTE_READY`, and `BYTE_READ`/`BYTE_ERROR_CODE` keep their previous values.
- **`READ_ENABLE` deasserted mid-frame:** the frame still completes and is delivered.
- **Reset values:**
  - State IDLE.
  - `BYTE_READ`=8'h00, `BYTE_ERROR_CODE`=2'b00, `BYTE_READY`=0.
  - Synchronizer flops=1 (idle-high lines).
  - Counters 0.
  - Reset mid-frame discards the partial frame.
- `BYTE_READ` and `BYTE_ERROR_CODE` hold their values until the next DONE.

## Timing
- **Edge detect latency:** if a `CLK_MOUSE_IN` falling edge is setup-valid before `CLK` rising edge k, `fall` is high during the cycle after edge k+1.
- **`BYTE_READY` latency:** `BYTE_READY` is high during the cycle after edge k+2 for the stop-bit edge, so end-to-end latency is 3 `CLK` cycles from the stop-bit edge (+1 from input asynchrony).
- `BYTE_READY` is exactly one cycle wide.
- Back-to-back frames need no gap: DONE lasts one cycle, and the PS/2 clock period (≥60 µs) is far longer.
- A `fall` arriving in the DONE cycle is impossible at legal PS/2 rates. If it does arrive, it is ignored.
- The watchdog counter is ⌈log2(`TIMEOUT_CYCLES`)⌉ bits wide and never wraps.

## Structure
- **Shared package `mouse_pkg`:**
  - state encoding (3-bit: IDLE=0, DATA=1, PARITY=2, STOP=3, DONE=4);
  - error-code constants `ERR_NONE`=2'b00, `ERR_PARITY`=2'b01, `ERR_STOP`=2'b10;
  - PS/2 frame length constant 11.
- The transmitter and master reuse the same package.
- **Sub-module `ps2_line_sync`:** 2-flop synchronizers for both lines plus falling-edge detect. Outputs synced data and `fall`. The transmitter reuses it.

## Test plan
1. **Good frame:** with `READ_ENABLE`=1, mouse sends 0xFA (parity bit 1, stop 1) at a 40 µs half-period → `BYTE_READY` pulses once, `BYTE_READ`=8'hFA, `BYTE_ERROR_CODE`=2'b00.
2. **Bad parity:** frame 0xAA with parity bit 0 → `BYTE_READY` pulses, `BYTE_READ`=8'hAA, `BYTE_ERROR_CODE`=2'b01. Frame 0x00 with stop bit 0 → code 2'b10.
3. **Disabled and glitch:** with `READ_ENABLE`=0, frame 0x55 → no `BYTE_READY`, `BYTE_READ` unchanged. With `READ_ENABLE`=1, a single `fall` with data=1 → state stays IDLE, no strobe.
4. **Timeout:** send start plus 4 data bits, then hold the PS/2 clock high for `TIMEOUT_CYCLES`+10 cycles, then a full frame 0x08 → exactly one `BYTE_READY` with `BYTE_READ`=8'h08, code 2'b00.
5. **Reset mid-frame:** assert `RESET` for 2 cycles after the 5th data bit → all outputs at reset values. A following frame 0xF4 is received correctly.
6. **Back-to-back frames:** 0x00 then 0xFF with minimum inter-frame gap → two strobes with values 8'h00 and 8'hFF, both code 2'b00, each strobe 1 cycle wide.

Source files
------------

// File: rtl/mouse_pkg.sv
// mouse_pkg: shared PS/2 mouse types and constants (receiver, transmitter, master)
package mouse_pkg;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DATA   = 3'd1,
      ST_PARITY = 3'd2,
      ST_STOP   = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   typedef logic [1:0] err_code_t;

   localparam err_code_t ERR_NONE   = 2'b00;
   localparam err_code_t ERR_PARITY = 2'b01;
   localparam err_code_t ERR_STOP   = 2'b10;

   localparam int FRAME_BITS = 11;

   // odd parity holds when the 8 data bits plus the parity bit contain an odd number of ones
   function automatic logic parity_ok(input logic [7:0] b, input logic p);
      return ^{b, p};
   endfunction
endpackage

// File: rtl/mouse_receiver_if.sv
// mouse_receiver_if: PS/2 pad lines, read enable and decoded-byte handoff
//   CLK_MOUSE_IN/DATA_MOUSE_IN : PS/2 lines at the pad (asynchronous)
//   READ_ENABLE                : new frames accepted only while high
//   BYTE_READ/BYTE_ERROR_CODE  : last decoded byte and its error code
//   BYTE_READY                 : one-cycle strobe when a frame is delivered
interface mouse_receiver_if;
   import mouse_pkg::*;
   logic      CLK_MOUSE_IN;
   logic      DATA_MOUSE_IN;
   logic      READ_ENABLE;
   logic [7:0] BYTE_READ;
   err_code_t BYTE_ERROR_CODE;
   logic      BYTE_READY;
   modport master (
      output CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
      input  BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
   );
   modport slave (
      input  CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
      output BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
   );
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizers for the PS/2 lines plus falling-edge detect
//   clk/rst   : system clock, asynchronous active-high reset
//   ps2_clk   : raw PS/2 clock line
//   ps2_data  : raw PS/2 data line
//   data_sync : synchronized data line
//   fall      : high for one cycle per synchronized PS/2 clock falling edge
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic data_sync,
   output logic fall
);
   // clk_sr[0..1] synchronize, clk_sr[2] keeps the previous synced value
   logic [2:0] clk_sr;
   logic [1:0] data_sr;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         clk_sr  <= 3'b111;
         data_sr <= 2'b11;
      end else begin
         clk_sr  <= {clk_sr[1:0], ps2_clk};
         data_sr <= {data_sr[0], ps2_data};
      end
   assign data_sync = data_sr[1];
   assign fall      = clk_sr[2] & ~clk_sr[1];
endmodule

// File: rtl/mouse_receiver.sv
// mouse_receiver: decodes 11-bit PS/2 device-to-host frames into bytes with error codes
//   CLK/RESET : 50 MHz system clock, asynchronous active-high reset
//   bus       : slave side of mouse_receiver_if (PS/2 lines in, decoded byte out)
module mouse_receiver
   import mouse_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input logic             CLK,
   input logic             RESET,
   mouse_receiver_if.slave bus
);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   state_t          state, state_nxt;
   logic            data, fall, busy, timeout, par_err;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift, byte_q;
   err_code_t       code_q;
   logic [WD_W-1:0] wd;

   ps2_line_sync u_sync (
      .clk       (CLK),
      .rst       (RESET),
      .ps2_clk   (bus.CLK_MOUSE_IN),
      .ps2_data  (bus.DATA_MOUSE_IN),
      .data_sync (data),
      .fall      (fall)
   );

   assign busy    = state inside {ST_DATA, ST_PARITY, ST_STOP};
   assign timeout = busy && wd == WD_LAST;

   always_ff @(posedge CLK or posedge RESET)
      if (RESET) state <= ST_IDLE;
      else       state <= state_nxt;

   // a stalled frame is abandoned regardless of any edge in the same cycle
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   state_nxt = (fall && bus.READ_ENABLE && !data) ? ST_DATA : ST_IDLE;
         ST_DATA:   state_nxt = (fall && bit_cnt == 3'd7) ? ST_PARITY : ST_DATA;
         ST_PARITY: state_nxt = fall ? ST_STOP : ST_PARITY;
         ST_STOP:   state_nxt = fall ? ST_DONE : ST_STOP;
         default:   state_nxt = ST_IDLE;
      endcase
      if (timeout) state_nxt = ST_IDLE;
   end

   // outputs are loaded on entry to DONE so they are valid alongside the strobe
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         bit_cnt <= '0;
         shift   <= '0;
         par_err <= 1'b0;
         wd      <= '0;
         byte_q  <= '0;
         code_q  <= ERR_NONE;
      end else begin
         wd <= (busy && !fall) ? wd + 1'b1 : '0;
         if (state == ST_IDLE && state_nxt == ST_DATA) begin
            bit_cnt <= '0;
            shift   <= '0;
         end
         if (state == ST_DATA && fall) begin
            shift   <= {data, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (state == ST_PARITY && fall) par_err <= !parity_ok(shift, data);
         if (state == ST_STOP && state_nxt == ST_DONE) begin
            byte_q <= shift;
            code_q <= (par_err ? ERR_PARITY : ERR_NONE) | (data ? ERR_NONE : ERR_STOP);
         end
      end

   assign bus.BYTE_READ       = byte_q;
   assign bus.BYTE_ERROR_CODE = code_q;
   assign bus.BYTE_READY      = state == ST_DONE;
endmodule

// File: tb/tb_mouse_receiver.sv
// tb_mouse_receiver: directed PS/2 frames checked against a scoreboard of expected bytes
module tb_mouse_receiver;
   import mouse_pkg::*;

   localparam int TO = 200;
   localparam int H  = 20;

   typedef struct packed {
      logic [7:0] b;
      logic [1:0] c;
   } exp_t;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   exp_t sb[$];
   exp_t e_mon;
   int   total = 0;
   int   bad = 0;
   int   strobes = 0;
   int   s0;
   logic prev_ready = 1'b0;

   mouse_receiver_if bus ();

   mouse_receiver #(.TIMEOUT_CYCLES(TO)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   always #10 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (!RESET && bus.BYTE_READY === 1'b1) begin
         strobes++;
         chk("strobe_width", {31'd0, prev_ready}, 32'd0);
         chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            chk("byte_read", {24'd0, bus.BYTE_READ}, {24'd0, e_mon.b});
            chk("error_code", {30'd0, bus.BYTE_ERROR_CODE}, {30'd0, e_mon.c});
         end
      end
      prev_ready = bus.BYTE_READY;
   end

   task automatic ps2_bit(input logic d);
      bus.DATA_MOUSE_IN = d;
      repeat (H) @(negedge CLK);
      bus.CLK_MOUSE_IN = 1'b0;
      repeat (H) @(negedge CLK);
      bus.CLK_MOUSE_IN = 1'b1;
   endtask

   task automatic send(input logic [7:0] b, input logic par, input logic stop,
                       input int nbits, input logic deliver);
      logic [10:0] f;
      f = {stop, par, b, 1'b0};
      if (deliver) sb.push_back(exp_t'({b, ~stop, ~^{b, par}}));
      for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
      bus.DATA_MOUSE_IN = 1'b1;
   endtask

   task automatic good(input logic [7:0] b);
      send(b, ~^b, 1'b1, FRAME_BITS, 1'b1);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge CLK);
      chk(tag, sb.size(), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      bus.CLK_MOUSE_IN  = 1'b1;
      bus.DATA_MOUSE_IN = 1'b1;
      bus.READ_ENABLE   = 1'b1;
      repeat (3) @(negedge CLK);
      chk("rst_byte", {24'd0, bus.BYTE_READ}, 32'h00);
      chk("rst_code", {30'd0, bus.BYTE_ERROR_CODE}, 32'd0);
      chk("rst_ready", {31'd0, bus.BYTE_READY}, 32'd0);
      RESET = 1'b0;
      repeat (5) @(negedge CLK);

      good(8'hFA);
      drain("drain_fa");
      repeat (30) @(negedge CLK);
      chk("hold_fa", {24'd0, bus.BYTE_READ}, 32'hFA);
      chk("strobes_fa", strobes, 32'd1);

      send(8'hAA, 1'b0, 1'b1, FRAME_BITS, 1'b1);
      drain("drain_parity_err");
      send(8'h00, 1'b1, 1'b0, FRAME_BITS, 1'b1);
      drain("drain_stop_err");

      bus.READ_ENABLE = 1'b0;
      s0 = strobes;
      send(8'h55, ~^8'h55, 1'b1, FRAME_BITS, 1'b0);
      repeat (10) @(negedge CLK);
      chk("disabled_no_strobe", strobes, s0);
      chk("disabled_byte_held", {24'd0, bus.BYTE_READ}, 32'h00);
      chk("disabled_code_held", {30'd0, bus.BYTE_ERROR_CODE}, {30'd0, ERR_STOP});
      bus.READ_ENABLE = 1'b1;
      ps2_bit(1'b1);
      repeat (5) @(negedge CLK);
      chk("glitch_idle", {29'd0, dut.state}, {29'd0, ST_IDLE});
      chk("glitch_no_strobe", strobes, s0);

      send(8'h3C, 1'b0, 1'b1, 5, 1'b0);
      chk("partial_in_data", {29'd0, dut.state}, {29'd0, ST_DATA});
      repeat (TO + 10) @(negedge CLK);
      chk("timeout_idle", {29'd0, dut.state}, {29'd0, ST_IDLE});
      chk("timeout_no_strobe", strobes, s0);
      chk("timeout_byte_held", {24'd0, bus.BYTE_READ}, 32'h00);
      good(8'h08);
      drain("drain_after_timeout");
      chk("timeout_one_strobe", strobes, s0 + 1);

      send(8'hC3, 1'b1, 1'b1, 6, 1'b0);
      RESET = 1'b1;
      repeat (2) @(negedge CLK);
      chk("midrst_byte", {24'd0, bus.BYTE_READ}, 32'h00);
      chk("midrst_code", {30'd0, bus.BYTE_ERROR_CODE}, 32'd0);
      chk("midrst_ready", {31'd0, bus.BYTE_READY}, 32'd0);
      RESET = 1'b0;
      repeat (3) @(negedge CLK);
      chk("midrst_idle", {29'd0, dut.state}, {29'd0, ST_IDLE});
      good(8'hF4);
      drain("drain_f4");

      s0 = strobes;
      good(8'h00);
      good(8'hFF);
      drain("drain_b2b");
      chk("b2b_two_strobes", strobes, s0 + 2);

      repeat (10) @(negedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
